// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiplier / multiply-accumulate unit with architectural HI/LO.
// Four 16x16 partial-product steps per operation, then one FINISH cycle for sign fix-up and writeback.
module muldiv_seq (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        Flush,
  output logic        Stall,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic [31:0] Result,
  output logic [1:0]  dbg_state
);

  // Handshake: an op is taken only when Start is high in a cycle with Stall low,
  // or, for multicycle ops, when Start is high in IDLE (Stall then covers the issue
  // cycle). While Stall is high upstream must hold Start/Op/SrcA/SrcB steady.

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MADD  = 4'd3;
  localparam logic [3:0] OP_MADDU = 4'd4;
  localparam logic [3:0] OP_MSUB  = 4'd5;
  localparam logic [3:0] OP_MSUBU = 4'd6;
  localparam logic [3:0] OP_MUL   = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;
  localparam logic [3:0] OP_MFHI  = 4'd10;
  localparam logic [3:0] OP_MFLO  = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [1:0]  cnt;
  logic [63:0] acc;

  logic        mc_in, mf_in, accept;
  logic        signed_q, neg;
  logic [31:0] mag_a, mag_b;
  logic [15:0] half_a, half_b;
  logic [31:0] pp;
  logic [1:0]  shift_sel;
  logic [63:0] pp_sh, prod, hilo_next;

  assign mc_in  = (Op >= OP_MULT) && (Op <= OP_MUL);
  assign mf_in  = (Op >= OP_MTHI) && (Op <= OP_MFLO);
  assign accept = (state == S_IDLE) && Start && !Flush;

  // Magnitudes come from the latched operands; 0x80000000 negates to itself,
  // which read as unsigned is exactly 2^31.
  assign signed_q = (op_q == OP_MULT) || (op_q == OP_MADD) ||
                    (op_q == OP_MSUB) || (op_q == OP_MUL);
  assign mag_a    = (signed_q && a_q[31]) ? (~a_q + 32'd1) : a_q;
  assign mag_b    = (signed_q && b_q[31]) ? (~b_q + 32'd1) : b_q;
  assign neg      = signed_q && (a_q[31] ^ b_q[31]);

  // Step bit 1 picks the A half, bit 0 the B half; weight is 16*(k1+k0).
  assign half_a    = cnt[1] ? mag_a[31:16] : mag_a[15:0];
  assign half_b    = cnt[0] ? mag_b[31:16] : mag_b[15:0];
  assign pp        = {16'd0, half_a} * {16'd0, half_b};
  assign shift_sel = {1'b0, cnt[1]} + {1'b0, cnt[0]};
  assign pp_sh     = {32'd0, pp} << {shift_sel, 4'd0};
  assign prod      = neg ? (~acc + 64'd1) : acc;

  always_comb begin
    hilo_next = {Hi, Lo};
    case (op_q)
      OP_MULT, OP_MULTU: hilo_next = prod;
      OP_MADD, OP_MADDU: hilo_next = {Hi, Lo} + prod;
      OP_MSUB, OP_MSUBU: hilo_next = {Hi, Lo} - prod;
      default:           hilo_next = {Hi, Lo};
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    Done       = 1'b0;
    Result     = 32'd0;
    case (state)
      S_IDLE: begin
        if (accept && mc_in) next_state = S_CALC;
        if (Start && (Op == OP_MFHI)) Result = Hi;
        if (Start && (Op == OP_MFLO)) Result = Lo;
      end
      S_CALC: begin
        if (Flush)           next_state = S_IDLE;
        else if (cnt == 2'd3) next_state = S_FINISH;
      end
      S_FINISH: begin
        next_state = S_IDLE;
        Done       = !Flush;
        Result     = (op_q == OP_MUL) ? prod[31:0] : 32'd0;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign Busy      = (state != S_IDLE);
  assign Stall     = Busy || (Start && mc_in && (state == S_IDLE)) || (Start && mf_in && Busy);
  assign dbg_state = state;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      op_q <= 4'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      cnt  <= 2'd0;
      acc  <= 64'd0;
      Hi   <= 32'd0;
      Lo   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && mc_in) begin
            op_q <= Op;
            a_q  <= SrcA;
            b_q  <= SrcB;
            cnt  <= 2'd0;
            acc  <= 64'd0;
          end
          if (accept && (Op == OP_MTHI)) Hi <= SrcA;
          if (accept && (Op == OP_MTLO)) Lo <= SrcA;
        end
        S_CALC: begin
          if (Flush) begin
            cnt <= 2'd0;
          end else begin
            acc <= acc + pp_sh;
            cnt <= cnt + 2'd1;
          end
        end
        S_FINISH: begin
          if (!Flush) {Hi, Lo} <= hilo_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus randomized ops
// compared against a plain-arithmetic HI/LO model.
module tb_muldiv_seq;

  localparam logic [3:0] OP_NOP = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_MADD = 4'd3,
                         OP_MADDU = 4'd4, OP_MSUB = 4'd5, OP_MSUBU = 4'd6, OP_MUL = 4'd7,
                         OP_MTHI = 4'd8, OP_MTLO = 4'd9, OP_MFHI = 4'd10, OP_MFLO = 4'd11;

  logic        Clock, nReset, Start, Flush;
  logic [3:0]  Op;
  logic [31:0] SrcA, SrcB;
  logic        Stall, Busy, Done;
  logic [31:0] Hi, Lo, Result;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_seq dut (
    .Clock(Clock), .nReset(nReset), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .Flush(Flush), .Stall(Stall), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo),
    .Result(Result), .dbg_state(dbg_state)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference: full-width product from ordinary 64-bit arithmetic.
  function automatic logic [63:0] model_prod(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (op == OP_MULT || op == OP_MADD || op == OP_MSUB || op == OP_MUL) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic idle_inputs();
    Start = 1'b0; Op = OP_NOP; SrcA = 32'd0; SrcB = 32'd0; Flush = 1'b0;
  endtask

  task automatic do_mc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p, hilo;
    logic [31:0] exp_res;
    int cyc;
    bit seen;
    p = model_prod(op, a, b);
    hilo = {m_hi, m_lo};
    exp_res = (op == OP_MUL) ? p[31:0] : 32'd0;
    case (op)
      OP_MULT, OP_MULTU: hilo = p;
      OP_MADD, OP_MADDU: hilo = hilo + p;
      OP_MSUB, OP_MSUBU: hilo = hilo - p;
      default: ;
    endcase
    @(negedge Clock);
    Start = 1'b1; Op = op; SrcA = a; SrcB = b; #1;
    checks++;
    if (Stall !== 1'b1) begin errors++; $display("FAIL issue_stall op=%0d got %b exp 1", op, Stall); end
    cyc = 0; seen = 0;
    while (!seen && cyc < 10) begin
      @(negedge Clock);
      idle_inputs(); cyc++; #1;
      checks++;
      if (Stall !== 1'b1) begin errors++; $display("FAIL busy_stall op=%0d cyc=%0d got %b exp 1", op, cyc, Stall); end
      if (Done === 1'b1) begin
        seen = 1;
        checks++;
        if (cyc != 5) begin errors++; $display("FAIL done_latency op=%0d got %0d exp 5", op, cyc); end
        checks++;
        if (Result !== exp_res) begin errors++; $display("FAIL finish_result op=%0d got %h exp %h", op, Result, exp_res); end
      end
    end
    if (!seen) begin checks++; errors++; $display("FAIL done_timeout op=%0d got none exp pulse", op); end
    m_hi = hilo[63:32]; m_lo = hilo[31:0];
    @(negedge Clock); #1;
    checks++;
    if (Hi !== m_hi || Lo !== m_lo) begin
      errors++; $display("FAIL hilo op=%0d a=%h b=%h got %h_%h exp %h_%h", op, a, b, Hi, Lo, m_hi, m_lo);
    end
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL back_idle op=%0d got busy=%b done=%b exp 0 0", op, Busy, Done); end
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
    @(negedge Clock);
    Start = 1'b1; Op = op; SrcA = a; #1;
    checks++;
    if (Stall !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL mt_stall got stall=%b done=%b exp 0 0", Stall, Done); end
    if (op == OP_MTHI) m_hi = a; else m_lo = a;
    @(negedge Clock);
    idle_inputs(); #1;
    checks++;
    if (Hi !== m_hi || Lo !== m_lo) begin errors++; $display("FAIL mt_write got %h_%h exp %h_%h", Hi, Lo, m_hi, m_lo); end
  endtask

  task automatic do_mf(input logic [3:0] op);
    logic [31:0] exp_v;
    exp_v = (op == OP_MFHI) ? m_hi : m_lo;
    @(negedge Clock);
    Start = 1'b1; Op = op; #1;
    checks++;
    if (Result !== exp_v || Stall !== 1'b0) begin errors++; $display("FAIL mf_read op=%0d got %h stall=%b exp %h stall=0", op, Result, Stall, exp_v); end
    @(negedge Clock);
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    nReset = 1'b0;
    Start = 1'b1; Op = OP_MULT;
    repeat (2) @(negedge Clock);
    #1;
    checks++;
    if (Hi !== 32'd0 || Lo !== 32'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b exp 0", Hi, Lo, Busy, Done);
    end
    checks++;
    if (Stall !== 1'b1) begin errors++; $display("FAIL reset_start_stall got %b exp 1", Stall); end
    idle_inputs(); #1;
    checks++;
    if (Stall !== 1'b0 || Result !== 32'd0) begin errors++; $display("FAIL reset_outputs got stall=%b res=%h exp 0 0", Stall, Result); end
    nReset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_directed();
    do_mc(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    do_mc(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    do_mt(OP_MTHI, 32'h0000_0000);
    do_mt(OP_MTLO, 32'hFFFF_FFFF);
    do_mc(OP_MADDU, 32'd1, 32'd1);
    checks++;
    if (Hi !== 32'h1 || Lo !== 32'h0) begin errors++; $display("FAIL maddu_carry got %h_%h exp 00000001_00000000", Hi, Lo); end
    do_mt(OP_MTHI, 32'd0);
    do_mt(OP_MTLO, 32'd0);
    do_mc(OP_MSUB, 32'd1, 32'd1);
    checks++;
    if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL msub_wrap got %h_%h exp ffffffff_ffffffff", Hi, Lo); end
    do_mc(OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF);
    do_mc(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    do_mf(OP_MFHI);
    do_mf(OP_MFLO);
  endtask

  task automatic test_nop();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      Start = 1'b1; Op = (i == 0) ? OP_NOP : 4'($urandom_range(12, 15)); SrcA = $urandom(); #1;
      checks++;
      if (Stall !== 1'b0) begin errors++; $display("FAIL nop_stall op=%0d got %b exp 0", Op, Stall); end
      @(negedge Clock);
      idle_inputs(); #1;
      checks++;
      if (Busy !== 1'b0 || Hi !== m_hi || Lo !== m_lo) begin errors++; $display("FAIL nop_effect got busy=%b %h_%h exp 0 %h_%h", Busy, Hi, Lo, m_hi, m_lo); end
    end
  endtask

  task automatic test_hazard();
    logic [63:0] p;
    int cyc;
    bit seen;
    p = model_prod(OP_MULT, 32'h1234_5678, 32'hFEDC_BA98);
    @(negedge Clock);
    Start = 1'b1; Op = OP_MULT; SrcA = 32'h1234_5678; SrcB = 32'hFEDC_BA98;
    @(negedge Clock);
    Op = OP_MFHI; SrcA = $urandom(); SrcB = $urandom();
    cyc = 1; seen = 0;
    while (!seen && cyc < 10) begin
      #1;
      checks++;
      if (Stall !== 1'b1) begin errors++; $display("FAIL hazard_stall cyc=%0d got %b exp 1", cyc, Stall); end
      if (Done === 1'b1) seen = 1;
      @(negedge Clock);
      cyc++;
    end
    if (!seen) begin checks++; errors++; $display("FAIL hazard_timeout got none exp done"); end
    m_hi = p[63:32]; m_lo = p[31:0];
    #1;
    checks++;
    if (Stall !== 1'b0 || Result !== m_hi) begin errors++; $display("FAIL hazard_accept got stall=%b res=%h exp 0 %h", Stall, Result, m_hi); end
    @(negedge Clock);
    idle_inputs();
  endtask

  task automatic test_flush();
    bit any_done;
    do_mt(OP_MTHI, 32'hA5A5_0001);
    do_mt(OP_MTLO, 32'h5A5A_0002);
    @(negedge Clock);
    Start = 1'b1; Op = OP_MADD; SrcA = 32'h7FFF_FFFF; SrcB = 32'h7FFF_FFFF;
    any_done = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clock);
      idle_inputs();
      if (c == 3) Flush = 1'b1;
      #1;
      if (Done === 1'b1) any_done = 1;
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge Clock);
      idle_inputs(); #1;
      if (Done === 1'b1) any_done = 1;
    end
    checks++;
    if (any_done) begin errors++; $display("FAIL flush_done got pulse exp none"); end
    checks++;
    if (Busy !== 1'b0 || Hi !== m_hi || Lo !== m_lo) begin errors++; $display("FAIL flush_state got busy=%b %h_%h exp 0 %h_%h", Busy, Hi, Lo, m_hi, m_lo); end
    @(negedge Clock);
    Start = 1'b1; Op = OP_MTHI; SrcA = 32'hDEAD_BEEF; Flush = 1'b1;
    @(negedge Clock);
    Op = OP_MULT; #1;
    checks++;
    if (Hi !== m_hi) begin errors++; $display("FAIL flush_start_mt got %h exp %h", Hi, m_hi); end
    @(negedge Clock);
    idle_inputs(); #1;
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL flush_start_mc got busy=%b exp 0", Busy); end
  endtask

  task automatic test_reset_mid();
    bit any_done;
    do_mt(OP_MTHI, 32'h1111_2222);
    do_mt(OP_MTLO, 32'h3333_4444);
    @(negedge Clock);
    Start = 1'b1; Op = OP_MULTU; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF;
    @(negedge Clock);
    idle_inputs();
    @(negedge Clock);
    nReset = 1'b0; #1;
    checks++;
    if (Busy !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0 || Stall !== 1'b0) begin
      errors++; $display("FAIL midreset got busy=%b stall=%b %h_%h exp 0 0 0_0", Busy, Stall, Hi, Lo);
    end
    @(negedge Clock);
    nReset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    any_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clock); #1;
      if (Done === 1'b1 || Busy === 1'b1) any_done = 1;
    end
    checks++;
    if (any_done) begin errors++; $display("FAIL midreset_quiet got activity exp none"); end
    do_mc(OP_MADD, 32'hFFFF_FFFE, 32'h0000_0003);
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 11));
      if (op <= OP_MUL) do_mc(op, pick_operand(), pick_operand());
      else if (op <= OP_MTLO) do_mt(op, pick_operand());
      else do_mf(op);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_nop();
    test_hazard();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule
